audio_avg_filter: RTL and testbench

AUDIO_AVG_FILTER -- requirements
Module: audio_avg_filter

---
 rtl/audio_pkg.sv | 14 +
 rtl/avg_ring.sv | 48 ++++
 rtl/audio_avg_filter.sv | 85 ++++++++
 tb/tb_audio_avg_filter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and default sizing for the audio moving-average filter.
// No logic here: FSM state encoding plus default sample width / depth.
package audio_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int LOG2_N_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_SEND   = 2'd2
  } state_t;

endpackage

// File: rtl/avg_ring.sv
// One-channel N-deep moving-average core: ring of pre-scaled samples plus running sum.
// Latency: o_sum_nxt is combinational from i_sample; state advances on i_en; no backpressure.
module avg_ring #(
  parameter int DATA_W = 24,
  parameter int LOG2_N = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_sample,
  output logic [DATA_W-1:0] o_sum_nxt
);

  localparam int N = 1 << LOG2_N;

  logic signed [DATA_W-1:0] r_ring [N];
  logic        [LOG2_N-1:0] r_ptr;
  logic signed [DATA_W:0]   r_sum;

  logic signed [DATA_W-1:0] w_d;
  logic signed [DATA_W-1:0] w_old;
  logic signed [DATA_W:0]   w_d_ext;
  logic signed [DATA_W:0]   w_old_ext;
  logic signed [DATA_W:0]   w_sum_nxt;

  // Pre-scaling each sample by 1/N keeps the sum of N entries inside DATA_W.
  assign w_d       = $signed(i_sample) >>> LOG2_N;
  assign w_old     = r_ring[r_ptr];
  assign w_d_ext   = {w_d[DATA_W-1], w_d};
  assign w_old_ext = {w_old[DATA_W-1], w_old};
  assign w_sum_nxt = r_sum + w_d_ext - w_old_ext;
  assign o_sum_nxt = w_sum_nxt[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_ring[i] <= '0;
      end
      r_ptr <= '0;
      r_sum <= '0;
    end else if (i_en) begin
      r_ring[r_ptr] <= w_d;
      r_ptr         <= r_ptr + LOG2_N'(1);
      r_sum         <= w_sum_nxt;
    end
  end

endmodule

// File: rtl/audio_avg_filter.sv
// Stereo codec moving-average filter: read sample, update both rings, write result.
// Latency: 3 cycles per sample minimum; write_ready=0 stalls in SEND with outputs held.
module audio_avg_filter
  import audio_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LOG2_N = LOG2_N_DEF
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              read_ready,
  input  logic              write_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  input  logic              bypass,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right
);

  state_t            r_state;
  logic [DATA_W-1:0] r_cap_l;
  logic [DATA_W-1:0] r_cap_r;

  logic              w_take;
  logic              w_upd;
  logic [DATA_W-1:0] w_sum_l;
  logic [DATA_W-1:0] w_sum_r;

  // Strobes are gated by reset so nothing leaks out while reset is held.
  assign w_take = reset && (r_state == ST_IDLE) && read_ready && write_ready;
  assign w_upd  = (r_state == ST_UPDATE);
  assign read   = w_take;
  assign write  = reset && (r_state == ST_SEND) && write_ready;

  avg_ring #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_ring_l (
    .clk       (CLOCK_50),
    .rst_n     (reset),
    .i_en      (w_upd),
    .i_sample  (r_cap_l),
    .o_sum_nxt (w_sum_l)
  );

  avg_ring #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_ring_r (
    .clk       (CLOCK_50),
    .rst_n     (reset),
    .i_en      (w_upd),
    .i_sample  (r_cap_r),
    .o_sum_nxt (w_sum_r)
  );

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_cap_l         <= '0;
      r_cap_r         <= '0;
      writedata_left  <= '0;
      writedata_right <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_cap_l <= readdata_left;
            r_cap_r <= readdata_right;
            r_state <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          // Rings advance regardless of bypass so the average stays current.
          writedata_left  <= bypass ? r_cap_l : w_sum_l;
          writedata_right <= bypass ? r_cap_r : w_sum_r;
          r_state         <= ST_SEND;
        end
        ST_SEND: begin
          if (write_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_avg_filter.sv
// Directed bench for audio_avg_filter (DATA_W=24, LOG2_N=3) with hand-computed expectations.
module tb_audio_avg_filter;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        read_ready;
  logic        write_ready;
  logic [23:0] readdata_left;
  logic [23:0] readdata_right;
  logic        bypass;
  logic        read;
  logic        write;
  logic [23:0] writedata_left;
  logic [23:0] writedata_right;

  int vectors     = 0;
  int miscompares = 0;

  audio_avg_filter #(.DATA_W(24), .LOG2_N(3)) dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .read_ready      (read_ready),
    .write_ready     (write_ready),
    .readdata_left   (readdata_left),
    .readdata_right  (readdata_right),
    .bypass          (bypass),
    .read            (read),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered just after a falling edge with the DUT in IDLE; one full sample.
  task automatic xfer(input logic [23:0] l, input logic [23:0] r, input logic byp,
                      input logic [23:0] el, input logic [23:0] er);
    readdata_left  = l;
    readdata_right = r;
    bypass         = byp;
    read_ready     = 1'b1;
    write_ready    = 1'b1;
    #1;
    chk("read_idle", {23'd0, read}, 24'd1);
    chk("write_idle", {23'd0, write}, 24'd0);
    @(negedge CLOCK_50);
    read_ready = 1'b0;
    #1;
    chk("read_upd", {23'd0, read}, 24'd0);
    chk("write_upd", {23'd0, write}, 24'd0);
    @(negedge CLOCK_50);
    #1;
    chk("write_send", {23'd0, write}, 24'd1);
    chk("read_send", {23'd0, read}, 24'd0);
    chk("wd_left", writedata_left, el);
    chk("wd_right", writedata_right, er);
    @(negedge CLOCK_50);
    #1;
    chk("write_after", {23'd0, write}, 24'd0);
  endtask

  initial begin
    reset          = 1'b0;
    read_ready     = 1'b0;
    write_ready    = 1'b0;
    readdata_left  = 24'h0;
    readdata_right = 24'h0;
    bypass         = 1'b0;

    // Reset held: handshake inputs toggled, strobes and data stay quiet.
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK_50);
      read_ready     = i[0];
      write_ready    = i[1];
      readdata_left  = 24'h7FFFFF;
      #1;
      chk("rst_read", {23'd0, read}, 24'd0);
      chk("rst_write", {23'd0, write}, 24'd0);
      chk("rst_wdl", writedata_left, 24'h0);
      chk("rst_wdr", writedata_right, 24'h0);
    end
    @(negedge CLOCK_50);
    read_ready  = 1'b0;
    write_ready = 1'b0;
    reset       = 1'b1;

    // Step: left 0x800 -> d=0x100; right -8 -> d=-1. Saturates after 8 samples.
    for (int k = 1; k <= 10; k++) begin
      int m;
      m = (k > 8) ? 8 : k;
      xfer(24'h000800, 24'hFFFFF8, 1'b0, 24'(m * 256), 24'(-m));
    end

    // Backpressure: left 0x1000 (d=0x200) replaces a 0x100 slot -> 0x900.
    readdata_left  = 24'h001000;
    readdata_right = 24'hFFFFF8;
    bypass         = 1'b0;
    read_ready     = 1'b1;
    write_ready    = 1'b1;
    #1;
    chk("bp_read", {23'd0, read}, 24'd1);
    @(negedge CLOCK_50);
    write_ready = 1'b0;
    @(negedge CLOCK_50);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_write_hold", {23'd0, write}, 24'd0);
      chk("bp_read_hold", {23'd0, read}, 24'd0);
      chk("bp_wdl_hold", writedata_left, 24'h000900);
      chk("bp_wdr_hold", writedata_right, 24'hFFFFF8);
      @(negedge CLOCK_50);
    end
    write_ready = 1'b1;
    #1;
    chk("bp_write_rel", {23'd0, write}, 24'd1);
    chk("bp_read_rel", {23'd0, read}, 24'd0);
    read_ready = 1'b0;
    @(negedge CLOCK_50);
    #1;
    chk("bp_write_once", {23'd0, write}, 24'd0);

    // Reset mid-UPDATE after four samples.
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      xfer(24'h000800, 24'h000000, 1'b0, 24'(k * 256), 24'h0);
    end
    readdata_left  = 24'h000800;
    readdata_right = 24'h000000;
    read_ready     = 1'b1;
    write_ready    = 1'b1;
    #1;
    chk("mid_read", {23'd0, read}, 24'd1);
    @(negedge CLOCK_50);
    reset      = 1'b0;
    read_ready = 1'b0;
    #1;
    chk("mid_rst_write", {23'd0, write}, 24'd0);
    chk("mid_rst_wdl", writedata_left, 24'h0);
    @(negedge CLOCK_50);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("mid_no_write", {23'd0, write}, 24'd0);
      @(negedge CLOCK_50);
    end
    xfer(24'h000800, 24'h000000, 1'b0, 24'h000100, 24'h0);

    // Bypass: d_left = 0x123456>>>3 = 0x02468A, 8*d = 0x123450;
    // d_right = 0x800001>>>3 = 0xF00000 (-0x100000), 8*d = -0x800000.
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      xfer(24'h123456, 24'h800001, 1'b1, 24'h123456, 24'h800001);
    end
    xfer(24'h123456, 24'h800001, 1'b0, 24'h123450, 24'h800000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
